// File: rtl/watch_set_ctrl.sv
// Time-set control: routes UP/DOWN presses to the selected field with hold auto-repeat and release lock.
// Optional build macro WATCH_SET_ACCEL_EN shortens the repeat spacing after ACCEL_AFTER repeat ticks.
module watch_set_ctrl #(
  parameter int unsigned NUM_FIELDS    = 3,
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned ACCEL_AFTER   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic [NUM_FIELDS-1:0]         sw_sel,
  output logic [NUM_FIELDS-1:0]         tick_up,
  output logic [NUM_FIELDS-1:0]         tick_down,
  output logic [$clog2(NUM_FIELDS)-1:0] sel_idx,
  output logic                          busy
);

  localparam int unsigned IDX_W   = $clog2(NUM_FIELDS);
  localparam int unsigned CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT, LOCK} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    dir_down;
  logic                    btn_up_q;
  logic                    btn_down_q;
  logic [IDX_W-1:0]        sel_nxt;
  logic [NUM_FIELDS-1:0]   sel_mask;
  logic                    rise_up;
  logic                    rise_down;
  logic                    held;
  logic                    opposite;
  logic [CNT_W-1:0]        rep_reload;

  // Highest set select bit wins; no bit set keeps the current field
  always_comb begin
    sel_nxt = sel_idx;
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      if (sw_sel[i]) sel_nxt = IDX_W'(i);
    end
  end

  assign sel_mask  = NUM_FIELDS'(1) << sel_nxt;
  assign rise_up   = btn_up & ~btn_up_q;
  assign rise_down = btn_down & ~btn_down_q;
  assign held      = dir_down ? btn_down : btn_up;
  assign opposite  = dir_down ? btn_up : btn_down;

`ifdef WATCH_SET_ACCEL_EN
  localparam int unsigned REP_W       = (ACCEL_AFTER > 1) ? $clog2(ACCEL_AFTER + 1) : 1;
  localparam int unsigned FAST_PERIOD = (REPEAT_PERIOD / 4 >= 1) ? REPEAT_PERIOD / 4 : 1;

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_inc;

  // Repeat tick count after the tick being emitted now, saturating at ACCEL_AFTER
  always_comb begin
    rep_inc = (32'(rep_cnt) >= ACCEL_AFTER) ? rep_cnt : rep_cnt + REP_W'(1);
    rep_reload = (32'(rep_inc) >= ACCEL_AFTER) ? CNT_W'(FAST_PERIOD - 1)
                                               : CNT_W'(REPEAT_PERIOD - 1);
  end
`else
  assign rep_reload = CNT_W'(REPEAT_PERIOD - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dir_down   <= 1'b0;
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
      sel_idx    <= '0;
      tick_up    <= '0;
      tick_down  <= '0;
      busy       <= 1'b0;
`ifdef WATCH_SET_ACCEL_EN
      rep_cnt    <= '0;
`endif
    end else begin
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      sel_idx    <= sel_nxt;
      tick_up    <= '0;
      tick_down  <= '0;
      busy       <= 1'b0;
`ifdef WATCH_SET_ACCEL_EN
      rep_cnt    <= '0;
`endif
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise_up && rise_down) begin
              state <= LOCK;
            end else if (rise_up) begin
              if (btn_down) begin
                state <= LOCK;
              end else begin
                state    <= HOLD_WAIT;
                dir_down <= 1'b0;
                cnt      <= CNT_W'(HOLD_DELAY - 1);
                tick_up  <= sel_mask;
                busy     <= 1'b1;
              end
            end else if (rise_down) begin
              if (btn_up) begin
                state <= LOCK;
              end else begin
                state     <= HOLD_WAIT;
                dir_down  <= 1'b1;
                cnt       <= CNT_W'(HOLD_DELAY - 1);
                tick_down <= sel_mask;
                busy      <= 1'b1;
              end
            end
          end
          HOLD_WAIT, REPEAT: begin
            if (!held) begin
              state <= IDLE;
            end else if (opposite || (sel_nxt != sel_idx)) begin
              state <= LOCK;
            end else begin
              busy <= 1'b1;
              if (cnt == '0) begin
                state <= REPEAT;
                if (dir_down) tick_down <= sel_mask;
                else          tick_up   <= sel_mask;
`ifdef WATCH_SET_ACCEL_EN
                if (state == REPEAT) begin
                  cnt     <= rep_reload;
                  rep_cnt <= rep_inc;
                end else begin
                  cnt <= CNT_W'(REPEAT_PERIOD - 1);
                end
`else
                cnt <= rep_reload;
`endif
              end else begin
                cnt <= cnt - CNT_W'(1);
`ifdef WATCH_SET_ACCEL_EN
                rep_cnt <= rep_cnt;
`endif
              end
            end
          end
          LOCK: begin
            if (!btn_up && !btn_down) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed plus randomized bench for watch_set_ctrl against a press-timeline reference model.
module tb_watch_set_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned HD = 10;
  localparam int unsigned RP = 4;
  localparam int unsigned AA = 2;
  localparam int unsigned IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, en, btn_up, btn_down;
  logic [N-1:0]  sw_sel;
  logic [N-1:0]  tick_up, tick_down;
  logic [IW-1:0] sel_idx;
  logic          busy;

  always #5 clk = ~clk;

  watch_set_ctrl #(
    .NUM_FIELDS(N), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .ACCEL_AFTER(AA)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .btn_up(btn_up), .btn_down(btn_down),
    .sw_sel(sw_sel), .tick_up(tick_up), .tick_down(tick_down),
    .sel_idx(sel_idx), .busy(busy)
  );

  // Model: mode 0 = waiting for a press, 1 = press active, 2 = locked out
  int           m_mode, m_start, m_sel, cyc;
  bit           m_dir, m_pu, m_pd;
  logic [N-1:0] e_up, e_dn;
  logic         e_busy;
  int           npass = 0;
  int           nchk  = 0;

  function automatic int hi_idx(input logic [N-1:0] s, input int cur);
    int r = cur;
    for (int i = 0; i < int'(N); i++) if (s[i]) r = i;
    return r;
  endfunction

  // Is a tick due d cycles after the first tick of the press?
  function automatic bit due(input int d);
`ifdef WATCH_SET_ACCEL_EN
    int fast = (RP / 4 >= 1) ? int'(RP / 4) : 1;
    int k0   = int'(HD + AA * RP);
    if (d > k0) return ((d - k0) % fast) == 0;
`endif
    if (d == int'(HD)) return 1'b1;
    return (d > int'(HD)) && (((d - int'(HD)) % int'(RP)) == 0);
  endfunction

  task automatic model_edge();
    int ns;
    bit ru, rd, fire, held, opp;
    logic [N-1:0] vec;
    e_up = '0;
    e_dn = '0;
    fire = 1'b0;
    if (rst) begin
      m_mode = 0; m_sel = 0; m_pu = 1'b0; m_pd = 1'b0; e_busy = 1'b0;
      return;
    end
    ns = hi_idx(sw_sel, m_sel);
    ru = btn_up && !m_pu;
    rd = btn_down && !m_pd;
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (ru && btn_down)      m_mode = 2;
      else if (rd && btn_up)   m_mode = 2;
      else if (ru || rd) begin
        m_mode = 1; m_start = cyc; m_dir = rd; fire = 1'b1;
      end
    end else if (m_mode == 1) begin
      held = m_dir ? btn_down : btn_up;
      opp  = m_dir ? btn_up : btn_down;
      if (!held)                      m_mode = 0;
      else if (opp || ns != m_sel)    m_mode = 2;
      else if (due(cyc - m_start))    fire = 1'b1;
    end else if (!btn_up && !btn_down) begin
      m_mode = 0;
    end
    if (fire) begin
      vec = N'(1) << ns;
      if (m_dir) e_dn = vec;
      else       e_up = vec;
    end
    m_pu = btn_up;
    m_pd = btn_down;
    m_sel = ns;
    e_busy = (m_mode == 1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("tick_up", 32'(tick_up), 32'(e_up));
    check("tick_down", 32'(tick_down), 32'(e_dn));
    check("sel_idx", 32'(sel_idx), 32'(m_sel));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_mode = 0; m_start = 0; m_sel = 0; cyc = 0;
    m_dir = 1'b0; m_pu = 1'b0; m_pd = 1'b0;
    rst = 1'b1; en = 1'b1; btn_up = 1'b0; btn_down = 1'b0; sw_sel = 3'b010;
    steps(2);
    rst = 1'b0;
    steps(2);
    // short press on field 1
    btn_up = 1'b1; steps(3);
    btn_up = 1'b0; steps(4);
    // long hold on field 2: first tick, hold delay, then repeats
    sw_sel = 3'b100;
    btn_down = 1'b1; steps(30);
    btn_down = 1'b0; steps(3);
    // field change mid-hold locks until full release and a fresh edge
    sw_sel = 3'b001;
    btn_up = 1'b1; steps(5);
    sw_sel = 3'b010; steps(15);
    btn_up = 1'b0; steps(2);
    btn_up = 1'b1; steps(3);
    btn_up = 1'b0; steps(2);
    // simultaneous rise locks; release of one is not enough
    btn_up = 1'b1; btn_down = 1'b1; steps(3);
    btn_down = 1'b0; steps(3);
    btn_up = 1'b0; steps(2);
    btn_up = 1'b1; steps(2);
    btn_up = 1'b0; steps(2);
    // rising while the other is already held
    btn_down = 1'b1; steps(2);
    btn_up = 1'b1; steps(3);
    btn_up = 1'b0; btn_down = 1'b0; steps(2);
    // reset during REPEAT
    sw_sel = 3'b001;
    btn_up = 1'b1; steps(16);
    rst = 1'b1; step();
    rst = 1'b0; steps(3);
    btn_up = 1'b0; steps(2);
    // enable dropped during HOLD_WAIT, button still held when enable returns
    btn_down = 1'b1; steps(4);
    en = 1'b0; steps(2);
    en = 1'b1; steps(12);
    btn_down = 1'b0; steps(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) btn_up = ~btn_up;
      if ($urandom_range(13) == 0) btn_down = ~btn_down;
      if ($urandom_range(24) == 0) sw_sel = N'($urandom_range(7));
      if ($urandom_range(59) == 0) en = ~en;
      else if (!en && $urandom_range(3) == 0) en = 1'b1;
      rst = ($urandom_range(299) == 0);
      step();
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
